// File: rtl/lsu_mem_master.sv
// Load/store initiator for a word-addressed, big-endian data memory.
// Sub-word stores are done as read-modify-write; sub-word loads are extended.
module lsu_mem_master #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  logic [1:0]  state;
  logic        err_p0;
  logic        write_p0;
  logic        unsigned_p0;
  logic [1:0]  size_p0;
  logic [1:0]  off_p0;
  logic [31:0] wdata_p0;
  logic [31:0] rword_p1;
  logic        accept;
  logic        bad;

  function automatic logic req_bad(input logic [1:0] size, input logic [31:0] addr);
    logic [31:0] idx;
    idx = addr >> 2;
    return (size == 2'b11) ||
           (size == SZ_HALF && addr[0]) ||
           (size == SZ_WORD && addr[1:0] != 2'b00) ||
           (idx >= 32'(MEM_WORDS));
  endfunction

  // Byte offset 0 is the most significant byte of the word.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    case (size)
      SZ_BYTE: return uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] off);
    logic [31:0] m;
    m = word;
    case (size)
      SZ_BYTE: begin
        case (off)
          2'd0:    m[31:24] = wdata[7:0];
          2'd1:    m[23:16] = wdata[7:0];
          2'd2:    m[15:8]  = wdata[7:0];
          default: m[7:0]   = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (off[1]) m[15:0] = wdata[15:0];
        else        m[31:16] = wdata[15:0];
      end
      default: m = wdata;
    endcase
    return m;
  endfunction

  assign req_ready = (state == S_IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign bad       = req_bad(req_size, req_addr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      err_p0   <= 1'b0;
      mem_addr <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            err_p0   <= bad;
            mem_addr <= {req_addr[31:2], 2'b00};
            if (bad)                                  state <= S_RESP;
            else if (!req_write || req_size != SZ_WORD) state <= S_READ;
            else                                      state <= S_WRITE;
          end
        end
        S_READ:  state <= write_p0 ? S_WRITE : S_RESP;
        S_WRITE: state <= S_RESP;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Request capture at accept, memory word capture at the end of READ.
  always_ff @(posedge clk) begin
    if (accept) begin
      write_p0    <= req_write;
      size_p0     <= req_size;
      unsigned_p0 <= req_unsigned;
      off_p0      <= req_addr[1:0];
      wdata_p0    <= req_wdata;
    end
    if (state == S_READ) rword_p1 <= mem_rdata;
  end

  assign mem_read   = (state == S_READ) && !reset;
  assign mem_write  = (state == S_WRITE) && !reset;
  assign mem_wdata  = mem_write ? store_merge(rword_p1, wdata_p0, size_p0, off_p0) : 32'h0;
  assign resp_valid = (state == S_RESP) && !reset;
  assign resp_err   = resp_valid && err_p0;
  assign resp_rdata = (resp_valid && !err_p0 && !write_p0)
                      ? load_extend(rword_p1, size_p0, off_p0, unsigned_p0) : 32'h0;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: attached memory model plus an arithmetic reference
// model of the load/store rules, directed cases followed by random requests.
module tb_lsu_mem_master;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem_read ? mem[mem_addr[7:2]] : 32'h0;

  lsu_mem_master #(.MEM_WORDS(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge; the memory commits any write seen there.
  task automatic tick();
    @(negedge clk);
    if (mem_write === 1'b1) mem[mem_addr[7:2]] = mem_wdata;
  endtask

  task automatic do_req(input string name, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input bit hold,
                        output int waited);
    logic        err;
    int          lat;
    int          sh;
    logic [5:0]  idx;
    logic [5:0]  erd, ewr, eresp, erdy, ard, awr, aresp, ardy;
    logic [31:0] erdata, ewdata, ardata, awdata, old, v, mask;
    logic        aerr, idle_ok, addr_ok;

    err = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0) ||
          ((addr >> 2) >= 32'd64);
    idx = addr[7:2];
    old = ref_mem[idx];
    erdata = 32'h0; ewdata = 32'h0; erd = 6'h0; ewr = 6'h0;
    sh = (sz == 2'd1) ? (addr[1] ? 0 : 16) : 8 * (3 - int'(addr[1:0]));
    if (err) begin
      lat = 1;
    end else if (!wr) begin
      lat = 2; erd = 6'b000010;
      if (sz == 2'd2) v = old;
      else if (sz == 2'd1) begin
        v = (old >> sh) & 32'hFFFF;
        if (!uns && v[15]) v = v | 32'hFFFF0000;
      end else begin
        v = (old >> sh) & 32'hFF;
        if (!uns && v[7]) v = v | 32'hFFFFFF00;
      end
      erdata = v;
    end else if (sz == 2'd2) begin
      lat = 2; ewr = 6'b000010; ewdata = wd;
    end else begin
      lat = 3; erd = 6'b000010; ewr = 6'b000100;
      mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
      ewdata = (old & ~mask) | ((wd << sh) & mask);
    end
    eresp = 6'd1 << lat;
    erdy  = 6'd1 << (lat + 1);

    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
    check({name, "_ready_at_accept"}, req_ready, 1);

    ard = 0; awr = 0; aresp = 0; ardy = 0;
    ardata = 'x; awdata = 'x; aerr = 1'bx; idle_ok = 1'b1; addr_ok = 1'b1;
    for (int c = 1; c <= lat + 1; c++) begin
      tick();
      if (c == 1 && !hold) req_valid = 1'b0;
      ard[c] = mem_read; awr[c] = mem_write; aresp[c] = resp_valid; ardy[c] = req_ready;
      if (resp_valid === 1'b1) begin
        ardata = resp_rdata; aerr = resp_err;
      end else if (resp_rdata !== 32'h0 || resp_err !== 1'b0) idle_ok = 1'b0;
      if (mem_write === 1'b1) awdata = mem_wdata;
      if ((mem_read === 1'b1 || mem_write === 1'b1) && mem_addr !== {addr[31:2], 2'b00})
        addr_ok = 1'b0;
    end

    check({name, "_read_cycles"}, ard, erd);
    check({name, "_write_cycles"}, awr, ewr);
    check({name, "_resp_cycle"}, aresp, eresp);
    check({name, "_ready_cycles"}, ardy, erdy);
    check({name, "_rdata"}, ardata, erdata);
    check({name, "_err"}, aerr, err);
    check({name, "_idle_zero"}, idle_ok, 1);
    check({name, "_mem_addr"}, addr_ok, 1);
    if (!err && wr) begin
      check({name, "_wdata"}, awdata, ewdata);
      ref_mem[idx] = ewdata;
      check({name, "_mem_word"}, mem[idx], ewdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    logic        rwr, runs;
    logic [1:0]  rsz;
    logic [31:0] raddr;

    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[1] = 32'h11223344; ref_mem[1] = 32'h11223344;
    mem[2] = 32'h80FF7F01; ref_mem[2] = 32'h80FF7F01;
    mem[3] = 32'hDEADBEEF; ref_mem[3] = 32'hDEADBEEF;

    // Reset state
    tick(); tick();
    check("rst_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    reset = 1'b0;
    tick();
    check("post_rst_ready", req_ready, 1);

    // Directed loads and stores
    do_req("lw_4",   1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 1'b0, w);
    do_req("lb_8",   1'b0, 2'd0, 1'b0, 32'h8, 32'h0, 1'b0, w);
    do_req("lbu_8",  1'b0, 2'd0, 1'b1, 32'h8, 32'h0, 1'b0, w);
    do_req("lh_a",   1'b0, 2'd1, 1'b0, 32'hA, 32'h0, 1'b0, w);
    do_req("lhu_8",  1'b0, 2'd1, 1'b1, 32'h8, 32'h0, 1'b0, w);
    do_req("sb_d",   1'b1, 2'd0, 1'b0, 32'hD, 32'h000000AB, 1'b0, w);
    check("sb_d_result", mem[3], 32'hDEABBEEF);

    // Error cases
    do_req("err_lw_6",   1'b0, 2'd2, 1'b0, 32'h6,   32'h0, 1'b0, w);
    do_req("err_sh_3",   1'b1, 2'd1, 1'b0, 32'h3,   32'h1234, 1'b0, w);
    do_req("err_lw_100", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b0, w);
    do_req("err_size3",  1'b0, 2'd3, 1'b0, 32'h0,   32'h0, 1'b0, w);

    // Back-to-back word stores with req_valid held high
    do_req("b2b_a", 1'b1, 2'd2, 1'b0, 32'h10, 32'hCAFEF00D, 1'b1, w);
    do_req("b2b_b", 1'b1, 2'd2, 1'b0, 32'h14, 32'h0BADBEEF, 1'b0, w);
    check("b2b_second_wait", w, 0);
    check("b2b_word4", mem[4], 32'hCAFEF00D);
    check("b2b_word5", mem[5], 32'h0BADBEEF);

    // Reset during the WRITE cycle of a byte store
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h1D; req_wdata = 32'h55;
    check("rstmid_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    check("rstmid_read_c1", mem_read, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    tick();
    check("rstmid_no_write", mem_write, 0);
    check("rstmid_no_resp", resp_valid, 0);
    check("rstmid_ready_in_reset", req_ready, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    check("rstmid_ready_after", req_ready, 1);
    check("rstmid_no_resp_after", resp_valid, 0);
    check("rstmid_no_write_after", mem_write, 0);
    check("rstmid_word_unchanged", mem[7], ref_mem[7]);

    // Random requests against the reference model
    for (int n = 0; n < 60; n++) begin
      rwr  = 1'($urandom_range(0, 1));
      runs = 1'($urandom_range(0, 1));
      rsz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      case ($urandom_range(0, 9))
        0:       raddr = 32'h100 + 32'($urandom_range(0, 63));
        1:       raddr = 32'hFFFF_FFFC;
        default: raddr = 32'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 2) != 0) begin
        if (rsz == 2'd2) raddr[1:0] = 2'b00;
        else if (rsz == 2'd1) raddr[0] = 1'b0;
      end
      do_req("rand", rwr, rsz, runs, raddr, $urandom, 1'b0, w);
    end

    for (int i = 0; i < 64; i++) check("final_mem", mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
